// File: rtl/droid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : droid_pkg
//  Purpose  : Shared opcode constants, FSM state encoding and the DataOut
//             status layout for the battle-droid command sequencer.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package droid_pkg;

   typedef enum logic [1:0] {
      ST_OFF       = 2'b00,
      ST_STANDBY   = 2'b01,
      ST_MOVING    = 2'b10,
      ST_ATTACKING = 2'b11
   } state_e;

   localparam logic [3:0] OP_NOOP     = 4'b0000;
   localparam logic [3:0] OP_STANDBY  = 4'b0100;
   localparam logic [3:0] OP_ATTACK   = 4'b0101;
   localparam logic [3:0] OP_GOTO     = 4'b0110;
   localparam logic [3:0] OP_TARGET   = 4'b0111;
   localparam logic [3:0] OP_RANK     = 4'b1000;
   localparam logic [3:0] OP_BATTERY  = 4'b1001;
   localparam logic [3:0] OP_ATLOC    = 4'b1010;
   localparam logic [3:0] OP_RESET    = 4'b1100;
   localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

   // DataOut layout returned by a NOOP readback
   typedef struct packed {
      logic [1:0] state;
      logic       err_sticky;
      logic       low_batt;
      logic [3:0] rsvd;
   } status_t;

   // Opcodes that may still be accepted while the droid is busy
   function automatic logic op_ok_when_busy(input logic [3:0] op);
      case (op)
         OP_NOOP, OP_STANDBY, OP_ATLOC, OP_RESET, OP_SHUTDOWN: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/battery_gauge.sv
`default_nettype none
// ============================================================================
//  Module   : battery_gauge
//  Purpose  : 8-bit saturating down-counter holding the droid battery level.
//  Ports    : clk, rst_n      clock / synchronous active-low reset (-> FULL)
//             load_i          load load_val_i (has priority over drain)
//             load_val_i      value to load
//             drain_i         subtract amt_i this cycle, saturating at 0
//             amt_i           drain amount
//             zero_o          registered level is 0
//             drain_to_zero_o level would be 0 after draining amt_i
//  Revision : 1.0  initial release
// ============================================================================
module battery_gauge #(
   parameter logic [7:0] FULL = 8'd255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       drain_i,
   input  logic [7:0] amt_i,
   output logic       zero_o,
   output logic       drain_to_zero_o
);

   logic [7:0] level_q, level_d;
   logic [7:0] w_drained;

   always_comb begin
      w_drained = (level_q > amt_i) ? (level_q - amt_i) : 8'd0;
      level_d   = level_q;
      if (load_i)
         level_d = load_val_i;
      else if (drain_i)
         level_d = w_drained;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         level_q <= FULL;
      else
         level_q <= level_d;
   end

   assign zero_o          = (level_q == 8'd0);
   assign drain_to_zero_o = (w_drained == 8'd0);

endmodule
`default_nettype wire

// File: rtl/droid_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : droid_cmd_sequencer
//  Purpose  : Accepts 4-bit droid commands over valid/ready, keeps the goto /
//             target / rank registers, runs the OFF/STANDBY/MOVING/ATTACKING
//             FSM and drains the battery gauge.
//  Ports    : clk, rst_n        clock / synchronous active-low reset
//             cmd_valid/ready   command handshake (ready is combinational)
//             opcode, DataIn, LocIn  command and operands
//             GPS               current position
//             state             00 OFF, 01 STANDBY, 10 MOVING, 11 ATTACKING
//             DataOut           registered readback
//             at_loc, low_batt  levels; arrived, err  1-cycle pulses
//             fire              high while ATTACKING
//  Revision : 1.0  initial release
// ============================================================================
module droid_cmd_sequencer
   import droid_pkg::*;
#(
   parameter logic [7:0]  BATT_FULL     = 8'd255,
   parameter logic [7:0]  MOVE_COST     = 8'd1,
   parameter logic [7:0]  ATTACK_COST   = 8'd4,
   parameter int unsigned ATTACK_CYCLES = 8,
   parameter int unsigned MOVE_TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  opcode,
   input  logic [7:0]  DataIn,
   input  logic [15:0] LocIn,
   input  logic [15:0] GPS,
   output logic [1:0]  state,
   output logic [7:0]  DataOut,
   output logic        at_loc,
   output logic        arrived,
   output logic        fire,
   output logic        low_batt,
   output logic        err
);

   state_e      state_q, state_d;
   logic [15:0] goto_q, goto_d, target_q, target_d;
   logic        tgt_valid_q, tgt_valid_d;
   logic [7:0]  rank_q, rank_d, dataout_q, dataout_d;
   logic        at_loc_q, at_loc_d, arrived_q, arrived_d;
   logic        err_q, err_d, err_sticky_q, err_sticky_d;
   logic [7:0]  move_cnt_q, move_cnt_d, atk_cnt_q, atk_cnt_d;

   logic        w_accept, w_soft_rst, w_busy, w_preempt, w_atk_ok, w_gps_hit;
   logic        w_batt_zero, w_drain_zero, w_batt_load;
   logic        w_exit_arrive, w_exit_timeout;
   logic [7:0]  w_batt_val, w_drain_amt;
   status_t     w_status;

   assign w_accept   = cmd_valid && cmd_ready;
   // The RESET opcode behaves exactly like one edge of rst_n
   assign w_soft_rst = w_accept && (opcode == OP_RESET);
   assign w_busy     = (state_q == ST_MOVING) || (state_q == ST_ATTACKING);
   // A preempting command overrides any internal exit in the same cycle
   assign w_preempt  = w_accept && w_busy &&
                       ((opcode == OP_STANDBY) || (opcode == OP_SHUTDOWN));
   assign w_atk_ok   = tgt_valid_q && !w_batt_zero;
   assign w_gps_hit  = (GPS == goto_q);

   assign w_drain_amt = (state_q == ST_ATTACKING) ? ATTACK_COST : MOVE_COST;
   assign w_batt_load = w_soft_rst ||
                        (w_accept && (state_q == ST_STANDBY) && (opcode == OP_BATTERY));
   assign w_batt_val  = w_soft_rst ? BATT_FULL : DataIn;

   battery_gauge #(.FULL(BATT_FULL)) u_gauge (
      .clk             (clk),
      .rst_n           (rst_n),
      .load_i          (w_batt_load),
      .load_val_i      (w_batt_val),
      .drain_i         (w_busy),
      .amt_i           (w_drain_amt),
      .zero_o          (w_batt_zero),
      .drain_to_zero_o (w_drain_zero)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n || w_soft_rst)
         state_q <= ST_STANDBY;
      else
         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d        = state_q;
      w_exit_arrive  = 1'b0;
      w_exit_timeout = 1'b0;
      case (state_q)
         ST_MOVING: begin
            if (w_gps_hit) begin
               state_d       = ST_STANDBY;
               w_exit_arrive = 1'b1;
            end else if (w_drain_zero) begin
               state_d = ST_STANDBY;
            end else if (move_cnt_q == 8'(MOVE_TIMEOUT)) begin
               state_d        = ST_STANDBY;
               w_exit_timeout = 1'b1;
            end
         end
         ST_ATTACKING: begin
            if ((atk_cnt_q == 8'(ATTACK_CYCLES - 1)) || w_drain_zero)
               state_d = ST_STANDBY;
         end
         default: ;
      endcase
      if (w_accept && (state_q != ST_OFF)) begin
         case (opcode)
            OP_SHUTDOWN: state_d = ST_OFF;
            OP_STANDBY:  state_d = ST_STANDBY;
            OP_GOTO:     state_d = ST_MOVING;
            OP_ATTACK:   if (w_atk_ok) state_d = ST_ATTACKING;
            default: ;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      cmd_ready = 1'b1;
      if (w_busy)
         cmd_ready = op_ok_when_busy(opcode);
      fire = (state_q == ST_ATTACKING);
   end

   // ---------------- operand / status registers ----------------
   assign w_status = '{state: state_q, err_sticky: err_sticky_q,
                       low_batt: w_batt_zero, rsvd: 4'b0000};

   always_comb begin
      goto_d      = goto_q;
      target_d    = target_q;
      tgt_valid_d = tgt_valid_q;
      rank_d      = rank_q;
      dataout_d   = dataout_q;
      move_cnt_d  = (state_q == ST_MOVING)    ? move_cnt_q + 8'd1 : move_cnt_q;
      atk_cnt_d   = (state_q == ST_ATTACKING) ? atk_cnt_q + 8'd1  : atk_cnt_q;
      at_loc_d    = w_gps_hit;
      arrived_d   = w_exit_arrive && !w_preempt;
      err_d       = w_exit_timeout && !w_preempt;
      // OFF drops everything silently; RESET is handled by the reset path
      if (w_accept && (state_q != ST_OFF)) begin
         case (opcode)
            OP_GOTO: begin
               goto_d     = LocIn;
               move_cnt_d = 8'd0;
            end
            OP_TARGET: begin
               target_d    = LocIn;
               tgt_valid_d = 1'b1;
            end
            OP_RANK: begin
               rank_d    = DataIn;
               dataout_d = DataIn;
            end
            OP_ATTACK: begin
               if (w_atk_ok) atk_cnt_d = 8'd0;
               else          err_d     = 1'b1;
            end
            OP_ATLOC: dataout_d = {7'b0, w_gps_hit};
            OP_NOOP:  dataout_d = w_status;
            OP_BATTERY, OP_STANDBY, OP_SHUTDOWN, OP_RESET: ;
            default:  err_d = 1'b1;
         endcase
      end
      err_sticky_d = err_sticky_q || err_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || w_soft_rst) begin
         goto_q       <= 16'd0;
         target_q     <= 16'd0;
         tgt_valid_q  <= 1'b0;
         rank_q       <= 8'd0;
         dataout_q    <= 8'd0;
         at_loc_q     <= 1'b0;
         arrived_q    <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         move_cnt_q   <= 8'd0;
         atk_cnt_q    <= 8'd0;
      end else begin
         goto_q       <= goto_d;
         target_q     <= target_d;
         tgt_valid_q  <= tgt_valid_d;
         rank_q       <= rank_d;
         dataout_q    <= dataout_d;
         at_loc_q     <= at_loc_d;
         arrived_q    <= arrived_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
         move_cnt_q   <= move_cnt_d;
         atk_cnt_q    <= atk_cnt_d;
      end
   end

   assign state    = state_q;
   assign DataOut  = dataout_q;
   assign at_loc   = at_loc_q;
   assign arrived  = arrived_q;
   assign err      = err_q;
   assign low_batt = w_batt_zero;

endmodule
`default_nettype wire

// File: tb/tb_droid_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_droid_cmd_sequencer
//  Purpose  : Self-checking bench: directed scenarios plus random commands,
//             expected per-cycle outputs from a behavioural droid model,
//             compared by an independent monitor at the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_droid_cmd_sequencer;

   localparam logic [3:0] T_NOOP = 4'b0000, T_STBY = 4'b0100, T_ATK = 4'b0101,
                          T_GOTO = 4'b0110, T_TGT = 4'b0111, T_RANK = 4'b1000,
                          T_BATT = 4'b1001, T_ATLOC = 4'b1010, T_RST = 4'b1100,
                          T_SHUT = 4'b1101;
   localparam logic [1:0] M_OFF = 2'b00, M_STB = 2'b01, M_MOV = 2'b10, M_ATK = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n, cmd_valid, cmd_ready;
   logic [3:0]  opcode;
   logic [7:0]  DataIn, DataOut;
   logic [15:0] LocIn, GPS;
   logic [1:0]  state;
   logic        at_loc, arrived, fire, low_batt, err;

   always #5 clk = ~clk;

   droid_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .opcode(opcode), .DataIn(DataIn), .LocIn(LocIn), .GPS(GPS),
      .state(state), .DataOut(DataOut), .at_loc(at_loc), .arrived(arrived),
      .fire(fire), .low_batt(low_batt), .err(err)
   );

   typedef struct {
      logic [1:0] st;
      logic [7:0] dout;
      logic       atl, arr, fir, lowb, er, rdy;
   } snap_t;

   snap_t exp_q[$];
   snap_t mon_e;
   int    n_total = 0, n_pass = 0, fire_seen = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural droid model ----------------
   logic [1:0]  m_state;
   int          m_batt, m_move_cycles, m_atk_cycles;
   logic [15:0] m_goto, m_tgt;
   logic        m_tv, m_atl, m_arr, m_err, m_sticky, m_valid = 1'b0;
   logic [7:0]  m_rank, m_dout;

   task automatic m_reset();
      m_state = M_STB; m_batt = 255; m_goto = 0; m_tgt = 0; m_tv = 0;
      m_rank = 0; m_dout = 0; m_atl = 0; m_arr = 0; m_err = 0; m_sticky = 0;
      m_move_cycles = 0; m_atk_cycles = 0;
   endtask

   function automatic logic m_ready(input logic [3:0] op);
      if (m_state == M_OFF || m_state == M_STB) return 1'b1;
      return op inside {T_NOOP, T_STBY, T_ATLOC, T_RST, T_SHUT};
   endfunction

   task automatic m_step(input bit rst, input bit v, input logic [3:0] op,
                         input logic [7:0] d, input logic [15:0] loc, input logic [15:0] gps);
      bit acc, narr, nerr, natl;
      int nb;
      logic [1:0] ns;
      if (!rst || (v && op == T_RST)) begin
         m_reset();
         return;
      end
      acc = v && m_ready(op);
      ns = m_state; nb = m_batt; narr = 0; nerr = 0;
      natl = (gps == m_goto);
      if (m_state == M_MOV) begin
         nb = (m_batt > 1) ? m_batt - 1 : 0;
         if (gps == m_goto) begin ns = M_STB; narr = 1; end
         else if (nb == 0) ns = M_STB;
         else if (m_move_cycles == 255) begin ns = M_STB; nerr = 1; end
         m_move_cycles++;
      end else if (m_state == M_ATK) begin
         nb = (m_batt > 4) ? m_batt - 4 : 0;
         if (m_atk_cycles == 7 || nb == 0) ns = M_STB;
         m_atk_cycles++;
      end
      if (acc && m_state != M_OFF) begin
         case (op)
            T_STBY:  begin ns = M_STB; narr = 0; nerr = 0; end
            T_SHUT:  begin ns = M_OFF; narr = 0; nerr = 0; end
            T_GOTO:  begin m_goto = loc; ns = M_MOV; m_move_cycles = 0; end
            T_TGT:   begin m_tgt = loc; m_tv = 1; end
            T_RANK:  begin m_rank = d; m_dout = d; end
            T_BATT:  nb = d;
            T_ATK:   if (m_tv && m_batt != 0) begin ns = M_ATK; m_atk_cycles = 0; end
                     else nerr = 1;
            T_ATLOC: m_dout = {7'b0, gps == m_goto};
            T_NOOP:  m_dout = {m_state, m_sticky, m_batt == 0, 4'b0000};
            default: nerr = 1;
         endcase
      end
      m_state = ns; m_batt = nb; m_arr = narr; m_err = nerr; m_atl = natl;
      m_sticky = m_sticky | nerr;
   endtask

   // ---------------- driver ----------------
   task automatic cyc(input bit rst, input bit v, input logic [3:0] op,
                      input logic [7:0] d, input logic [15:0] loc, input logic [15:0] gps);
      snap_t e;
      rst_n = rst; cmd_valid = v; opcode = op; DataIn = d; LocIn = loc; GPS = gps;
      if (m_valid) begin
         e.st = m_state; e.dout = m_dout; e.atl = m_atl; e.arr = m_arr;
         e.fir = (m_state == M_ATK); e.lowb = (m_batt == 0); e.er = m_err;
         e.rdy = m_ready(op);
         exp_q.push_back(e);
      end
      @(posedge clk);
      m_step(rst, v, op, d, loc, gps);
      m_valid = 1'b1;
      #1;
   endtask

   task automatic cmd(input logic [3:0] op, input logic [7:0] d, input logic [15:0] loc,
                      input logic [15:0] gps);
      cyc(1'b1, 1'b1, op, d, loc, gps);
   endtask

   task automatic idle(input int n, input logic [15:0] gps);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, T_NOOP, 8'd0, 16'd0, gps);
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (fire === 1'b1) fire_seen++;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("state",     16'(state),     16'(mon_e.st));
            chk("DataOut",   16'(DataOut),   16'(mon_e.dout));
            chk("at_loc",    16'(at_loc),    16'(mon_e.atl));
            chk("arrived",   16'(arrived),   16'(mon_e.arr));
            chk("fire",      16'(fire),      16'(mon_e.fir));
            chk("low_batt",  16'(low_batt),  16'(mon_e.lowb));
            chk("err",       16'(err),       16'(mon_e.er));
            chk("cmd_ready", 16'(cmd_ready), 16'(mon_e.rdy));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [3:0]  op_tab [16];
   logic [15:0] loc_tab [4];
   int          f0;

   initial begin
      op_tab  = '{T_NOOP, T_STBY, T_ATK, T_ATK, T_GOTO, T_GOTO, T_GOTO, T_TGT,
                  T_RANK, T_BATT, T_ATLOC, T_RST, T_SHUT, 4'b0011, 4'b1111, T_NOOP};
      loc_tab = '{16'h0203, 16'h0A0A, 16'h1111, 16'h0000};

      // reset
      cyc(1'b0, 1'b0, T_NOOP, 8'd0, 16'd0, 16'd0);
      cyc(1'b0, 1'b0, T_NOOP, 8'd0, 16'd0, 16'd0);
      idle(1, 16'd0);

      // travel and arrive
      cmd(T_GOTO, 8'd0, 16'h0203, 16'h0000);
      idle(5, 16'h0000);
      idle(3, 16'h0203);

      // attack without target, then with target
      cmd(T_ATK, 8'd0, 16'd0, 16'h0203);
      idle(1, 16'h0203);
      cmd(T_TGT, 8'd0, 16'h0A0A, 16'h0203);
      f0 = fire_seen;
      cmd(T_ATK, 8'd0, 16'd0, 16'h0203);
      idle(12, 16'h0203);
      chk("dir_fire_cycles", 16'(fire_seen - f0), 16'd8);
      cmd(T_NOOP, 8'd0, 16'd0, 16'h0203);

      // low battery abort
      cmd(T_BATT, 8'd3, 16'd0, 16'h0000);
      cmd(T_GOTO, 8'd0, 16'h7777, 16'h0000);
      idle(5, 16'h0000);
      cmd(T_NOOP, 8'd0, 16'd0, 16'h0000);

      // shutdown mid-move, ignored commands, RESET opcode
      cmd(T_RST, 8'd0, 16'd0, 16'h0000);
      cmd(T_GOTO, 8'd0, 16'h7777, 16'h0000);
      idle(2, 16'h0000);
      cmd(T_SHUT, 8'd0, 16'd0, 16'h0000);
      cmd(T_GOTO, 8'd0, 16'h5555, 16'h0000);
      cmd(T_RANK, 8'h55, 16'd0, 16'h0000);
      idle(1, 16'h0000);
      cmd(T_RST, 8'd0, 16'd0, 16'h0000);
      idle(1, 16'h0000);

      // RANK refused while moving, STANDBY preempt, illegal opcode
      cmd(T_GOTO, 8'd0, 16'h7777, 16'h0000);
      cmd(T_RANK, 8'h42, 16'd0, 16'h0000);
      cmd(T_STBY, 8'd0, 16'd0, 16'h0000);
      cmd(4'b0011, 8'h99, 16'h9999, 16'h0000);
      cmd(T_NOOP, 8'd0, 16'd0, 16'h0000);
      cmd(T_ATLOC, 8'd0, 16'd0, 16'h7777);
      idle(1, 16'h0000);

      // hardware reset while attacking
      cmd(T_TGT, 8'd0, 16'h0A0A, 16'h0000);
      cmd(T_ATK, 8'd0, 16'd0, 16'h0000);
      idle(3, 16'h0000);
      cyc(1'b0, 1'b0, T_NOOP, 8'd0, 16'd0, 16'h0000);
      idle(2, 16'h0000);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] gps_r, loc_r;
         logic [7:0]  d_r;
         gps_r = ($urandom_range(0, 7) == 0) ? 16'($urandom) : loc_tab[$urandom_range(0, 3)];
         loc_r = loc_tab[$urandom_range(0, 3)];
         d_r   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) < 2),
             op_tab[$urandom_range(0, 15)], d_r, loc_r, gps_r);
      end

      idle(2, 16'h0000);
      repeat (3) @(negedge clk);
      #1;
      chk("sb_drain", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
